// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter
//
// Shares one byte-wide memory between an instruction-fetch port and a data
// port. Each granted access moves one 32-bit word as four big-endian byte
// beats (beat 0 carries bits 31:24, beat 3 carries bits 7:0).
//
// Handshake: a requester holds *_req_i until it sees its *_gnt_o pulse.
// The grant takes effect on the rising edge that ends the cycle in which
// gnt is high. Requests in any other cycle are ignored. Completion is one
// *_valid_o pulse; *_rdata_o changes only in the cycle a read completes.
// On the memory side, a beat completes in any strobe cycle that has
// mem_ack_i high (a zero-wait ack is allowed). Without ack, the strobe,
// address and write byte all hold.
//
// Ports
//   clk_i, rst_i         clock (rising edge), async active-low reset
//   if_req_i/if_addr_i   fetch request and word address (read only)
//   if_gnt_o/if_valid_o  fetch accepted / done pulses; if_rdata_o fetched word
//   d_req_i/d_we_i       data request, 1 = store
//   d_addr_i/d_wdata_i   data word address / store word
//   d_gnt_o/d_valid_o    data accepted / done pulses; d_rdata_o loaded word
//   mem_*                byte memory: addr, read/write strobes, wdata, rdata, ack
//   err_o                access-abort pulse (watchdog build only, else 0)
//   dbg_state_o          current FSM state (IDLE=0, BEAT=1, DONE=2)
//
// Build option
//   MEM_ARB_TIMEOUT_EN   when defined, a 4-bit watchdog aborts an access
//                        after 16 consecutive BEAT cycles without an ack.
//                        err_o pulses and the FSM returns to IDLE with no valid.
module mem_arbiter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_valid_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_valid_o,
    output logic [31:0] d_rdata_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_re_o,
    output logic        mem_we_o,
    output logic [7:0]  mem_wdata_o,
    input  logic [7:0]  mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        err_o,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  beat_q;
    logic        last_data_q;   // 1 = data port was served last
    logic        owner_data_q;  // owner of the access in flight
    logic [29:0] addr_q;        // word address; byte lane comes from beat_q
    logic        we_q;
    logic [31:0] wdata_q;
    logic [23:0] acc_q;         // first three read bytes, oldest in the MSBs
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;

    logic        grant_fetch;
    logic        grant_data;
    logic        beat_ack;
    logic        last_beat;
    logic        timeout;
    logic [7:0]  wr_byte;

    // Word addresses ignore the byte-offset bits.
    logic        unused_addr_lsbs;
    assign unused_addr_lsbs = ^{if_addr_i[1:0], d_addr_i[1:0]};

    always_comb begin
        state_d     = state_q;
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        // Grants are gated by rst_i. Requests held during reset cannot
        // pulse a grant before reset has been released.
        if (state_q == IDLE && rst_i) begin
            if (if_req_i && d_req_i) begin
                // Round-robin on a tie: serve whoever did not go last.
                grant_fetch = last_data_q;
                grant_data  = ~last_data_q;
            end else begin
                grant_fetch = if_req_i;
                grant_data  = d_req_i;
            end
        end
        case (state_q)
            IDLE: if (grant_fetch || grant_data) state_d = BEAT;
            BEAT: begin
                if (last_beat)    state_d = DONE;
                else if (timeout) state_d = IDLE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign beat_ack  = (state_q == BEAT) && mem_ack_i;
    assign last_beat = beat_ack && (beat_q == 2'd3);

    always_comb begin
        wr_byte = 8'h00;
        case (beat_q)
            2'd0: wr_byte = wdata_q[31:24];
            2'd1: wr_byte = wdata_q[23:16];
            2'd2: wr_byte = wdata_q[15:8];
            2'd3: wr_byte = wdata_q[7:0];
            default: wr_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            beat_q       <= 2'd0;
            last_data_q  <= 1'b1;
            owner_data_q <= 1'b0;
            addr_q       <= 30'd0;
            we_q         <= 1'b0;
            wdata_q      <= 32'd0;
            acc_q        <= 24'd0;
            if_rdata_q   <= 32'd0;
            d_rdata_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            if (grant_fetch || grant_data) begin
                owner_data_q <= grant_data;
                last_data_q  <= grant_data;
                beat_q       <= 2'd0;
                addr_q       <= grant_data ? d_addr_i[31:2] : if_addr_i[31:2];
                we_q         <= grant_data && d_we_i;
                wdata_q      <= grant_data ? d_wdata_i : 32'd0;
            end
            if (beat_ack) begin
                beat_q <= beat_q + 2'd1;
                acc_q  <= {acc_q[15:0], mem_rdata_i};
                // The word is written one edge early, so it is already
                // on the rdata output during the DONE/valid cycle.
                if (last_beat && !we_q) begin
                    if (owner_data_q) d_rdata_q  <= {acc_q, mem_rdata_i};
                    else              if_rdata_q <= {acc_q, mem_rdata_i};
                end
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic [3:0] wd_q;
    logic       err_q;

    // wd_q == 15 with no ack means this is the 16th unacked BEAT cycle.
    assign timeout = (state_q == BEAT) && !mem_ack_i && (wd_q == 4'hF);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wd_q  <= 4'd0;
            err_q <= 1'b0;
        end else begin
            err_q <= timeout;
            if (state_q != BEAT || mem_ack_i) wd_q <= 4'd0;
            else                              wd_q <= wd_q + 4'd1;
        end
    end

    assign err_o = err_q;
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    assign if_gnt_o    = grant_fetch;
    assign d_gnt_o     = grant_data;
    assign if_valid_o  = (state_q == DONE) && !owner_data_q;
    assign d_valid_o   = (state_q == DONE) && owner_data_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign mem_re_o    = (state_q == BEAT) && !we_q;
    assign mem_we_o    = (state_q == BEAT) && we_q;
    assign mem_addr_o  = (state_q == BEAT) ? {addr_q, beat_q} : 32'd0;
    assign mem_wdata_o = (state_q == BEAT && we_q) ? wr_byte : 8'h00;
    assign dbg_state_o = state_q;

endmodule
